fibo_bin2bcd: RTL and testbench
===============================

// Module: fibo_bin2bcd
// PURPOSE
//  Downstream stage of fibonacci_calculator: converts its binary fibo_out word to packed BCD for display/compare.
//  Sequential double-dabble converter, one input bit per clock.
//  Launched by a start pulse (wired to the calculator's done rising edge); result held with done until next start.
// PARAMETERS
//  BIN_W   28  width of binary input (matches fibo_out)
//  DIGITS  7   BCD digits presented on bcd_out (4*DIGITS bits)
//  localparam FULL_DIG = (BIN_W*301+999)/1000 (9 for 28b): internal digit count, covers max bin_in
// PORTS
//  clk      in   1           rising-edge clock
//  reset    in   1           asynchronous, active-low reset
//  start    in   1           1-cycle request; bin_in sampled on same edge
//  bin_in   in   BIN_W       unsigned binary value (fibo_out)
//  bcd_out  out  4*DIGITS    packed BCD result, digit 0 in [3:0]
//  busy     out  1           conversion in progress
//  done     out  1           result valid; level, held until next accepted start
//  ovf      out  1           value exceeded 10**DIGITS-1 (meaning per CONFIGURATION)
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE; bcd_out=0, busy=0, done=0, ovf=0; shift reg and counter cleared.
//  States: IDLE -> SHIFT -> DONE -> (SHIFT on start) ; DONE persists otherwise.
//  IDLE/DONE + start=1 at edge E0: load shift reg={FULL_DIG*4'h0, bin_in}, bit counter=BIN_W-1, busy=1, done=0.
//  SHIFT, each edge: every 4b digit >=5 gets +3 (combinational), then whole reg shifts left 1; counter decrements.
//  Last shift occurs at edge E(BIN_W); same edge: bcd_out/ovf registered, busy=0, done=1, state=DONE.
//  Latency: done high after exactly BIN_W edges following E0 (28 cycles default); total start-to-done = BIN_W.
//  start while SHIFT: ignored, no restart, bin_in not resampled.
//  start while DONE: accepted; done drops at that edge, bcd_out keeps old value until new result lands.
//  bcd_out changes only on the completion edge or reset; never shows partial results.
//  Overflow: any of digits DIGITS..FULL_DIG-1 nonzero at completion. If DIGITS>=FULL_DIG, ovf is constant 0.
//  bin_in=0 -> bcd_out=0; all digits always in 0..9 (no illegal BCD codes ever output).
//  Reset mid-conversion: immediate return to IDLE, all outputs 0; next start works normally.
// CONFIGURATION
//  Macro FIBO_BCD_SAT_EN:
//   defined  : on overflow bcd_out = all digits 4'h9 (e.g. 0x9999999), ovf=1 until next accepted start/reset.
//   undefined: bcd_out = low DIGITS digits (value mod 10**DIGITS), ovf tied 0.
// STRUCTURE
//  fibo_pkg: FIB_W=28, BCD_DIGITS=7, typedef enum logic[1:0] {IDLE,SHIFT,DONE} bcd_state_t, typedef logic[3:0] bcd_digit_t.
//  Sub-module fibo_bcd_digit_adj: combinational 4b in -> (in>=5 ? in+3 : in), instantiated FULL_DIG times via generate.
//  Top holds FSM, bit counter ($clog2(BIN_W) bits), shift reg (4*FULL_DIG+BIN_W bits), output regs.
// TESTING
//  1. bin_in=9227465 (fib 35), start pulse -> done after 28 clks, bcd_out=28'h9227465, ovf=0.
//  2. bin_in=0, then bin_in=9999999 -> bcd_out=0x0000000, then 0x9999999; ovf=0 both.
//  3. bin_in=10000000: SAT_EN -> bcd_out=0x9999999 ovf=1; no SAT_EN -> bcd_out=0x0000000 ovf=0.
//  4. start again at cycle 10 of conversion of 55 -> ignored; result 0x0000055 at cycle 28.
//  5. reset low at cycle 14 of a conversion -> all outputs 0 immediately; new start 6765 -> 0x0006765.
//  6. chained with fibonacci_calculator, input_s=0..35 -> bcd_out matches fib_table.txt entry for each.

Source files
------------

// File: rtl/fibo_pkg.sv
// fibo_pkg: shared widths, FSM state and BCD digit type for the fibonacci display path.
package fibo_pkg;
    localparam int FIB_W      = 28;
    localparam int BCD_DIGITS = 7;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;
    typedef logic [3:0] bcd_digit_t;
endpackage

// File: rtl/fibo_bcd_digit_adj.sv
// fibo_bcd_digit_adj: double-dabble add-3 correction for one BCD digit.
module fibo_bcd_digit_adj
    import fibo_pkg::*;
(
    input  bcd_digit_t digit_i,
    output bcd_digit_t digit_o
);
    assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
endmodule

// File: rtl/fibo_bin2bcd.sv
// fibo_bin2bcd: sequential double-dabble binary-to-BCD converter, one input bit per clock.
// FIBO_BCD_SAT_EN: when defined, overflowing results saturate to all nines and raise ovf.
module fibo_bin2bcd
    import fibo_pkg::*;
#(
    parameter int BIN_W  = FIB_W,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin_in,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                busy,
    output logic                done,
    output logic                ovf
);
    localparam int FULL_DIG = (BIN_W*301+999)/1000;
    localparam int SW       = 4*FULL_DIG+BIN_W;
    localparam int CW       = $clog2(BIN_W);
    localparam int LO_DIG   = (DIGITS < FULL_DIG) ? DIGITS : FULL_DIG;

    bcd_state_t              state_q;
    logic [SW-1:0]           sr_q, sr_d;
    logic [CW-1:0]           cnt_q;
    logic [4*DIGITS-1:0]     bcd_q, bcd_d;
    logic                    busy_q, done_q, ovf_q, ovf_d;
    logic [4*FULL_DIG-1:0]   adj, bcd_full;
    logic [4*DIGITS-1:0]     bcd_low;

    for (genvar i = 0; i < FULL_DIG; i++) begin : g_adj
        fibo_bcd_digit_adj u_adj (
            .digit_i(sr_q[BIN_W+4*i +: 4]),
            .digit_o(adj[4*i +: 4])
        );
    end

    always_comb begin
        sr_d                   = {adj, sr_q[BIN_W-1:0]} << 1;
        bcd_full               = sr_d[SW-1:BIN_W];
        bcd_low                = '0;
        bcd_low[4*LO_DIG-1:0]  = bcd_full[4*LO_DIG-1:0];
    end

`ifdef FIBO_BCD_SAT_EN
    logic hi_nz;
    if (DIGITS < FULL_DIG) begin : g_hi
        assign hi_nz = |bcd_full[4*FULL_DIG-1:4*DIGITS];
    end else begin : g_nohi
        assign hi_nz = 1'b0;
    end
    assign ovf_d = hi_nz;
    assign bcd_d = hi_nz ? {DIGITS{4'h9}} : bcd_low;
`else
    assign ovf_d = 1'b0;
    assign bcd_d = bcd_low;
`endif

    // bcd_q/ovf_q only move on the completion edge, so partial results never leak out
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q != SHIFT && start) begin
            state_q <= SHIFT;
            sr_q    <= {{(4*FULL_DIG){1'b0}}, bin_in};
            cnt_q   <= CW'(BIN_W-1);
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == SHIFT) begin
            sr_q  <= sr_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
                state_q <= DONE;
                bcd_q   <= bcd_d;
                ovf_q   <= ovf_d;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end
        end
    end

    assign bcd_out = bcd_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ovf     = ovf_q;
endmodule

// File: tb/tb_fibo_bin2bcd.sv
// tb_fibo_bin2bcd: scoreboard bench; stimulus pushes expected results, a monitor checks each done rise.
module tb_fibo_bin2bcd;
    import fibo_pkg::*;
    localparam int BW = FIB_W;
    localparam int DG = BCD_DIGITS;

    logic            clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [BW-1:0]   bin_in = '0;
    logic [4*DG-1:0] bcd_out;
    logic            busy, done, ovf;

    typedef struct {
        logic [4*DG-1:0] bcd;
        logic            ovf;
        int              c0;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   errors = 0, checks = 0, cyc = 0;
    logic done_prev = 1'b0;

    fibo_bin2bcd dut (
        .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
        .bcd_out(bcd_out), .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
                e = q.pop_front();
                chk("bcd_out", 32'(bcd_out), 32'(e.bcd));
                chk("ovf", 32'(ovf), 32'(e.ovf));
                chk("latency", 32'(cyc - e.c0), 32'(BW));
            end
        end
        done_prev = done;
    end

    task automatic pulse(input logic [BW-1:0] v, input logic push, input logic [4*DG-1:0] eb, input logic eo);
        @(negedge clk);
        bin_in = v;
        start  = 1'b1;
        if (push) q.push_back('{eb, eo, cyc + 1});
        @(negedge clk);
        start  = 1'b0;
        bin_in = ~v;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 32'(done), 32'd1);
        @(negedge clk);
    endtask

    logic [BW-1:0]   vin[6];
    logic [4*DG-1:0] vexp[6];
    logic            vov[6];

    initial begin
        vin[0] = 28'd9227465;   vexp[0] = 28'h9227465; vov[0] = 1'b0;
        vin[1] = 28'd0;         vexp[1] = 28'h0000000; vov[1] = 1'b0;
        vin[2] = 28'd9999999;   vexp[2] = 28'h9999999; vov[2] = 1'b0;
        vin[4] = 28'd1234567;   vexp[4] = 28'h1234567; vov[4] = 1'b0;
        vin[3] = 28'd10000000;
        vin[5] = 28'd268435455;
`ifdef FIBO_BCD_SAT_EN
        vexp[3] = 28'h9999999; vov[3] = 1'b1;
        vexp[5] = 28'h9999999; vov[5] = 1'b1;
`else
        vexp[3] = 28'h0000000; vov[3] = 1'b0;
        vexp[5] = 28'h8435455; vov[5] = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_bcd", 32'(bcd_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            pulse(vin[i], 1'b1, vexp[i], vov[i]);
            wait_done();
        end

        // restart from DONE: done drops, old result held, mid-run start ignored
        pulse(28'd9227465, 1'b1, 28'h9227465, 1'b0);
        wait_done();
        pulse(28'd55, 1'b1, 28'h0000055, 1'b0);
        chk("restart_done_low", 32'(done), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_hold", 32'(bcd_out), 32'h9227465);
        repeat (8) @(negedge clk);
        bin_in = 28'd777;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        chk("ignored_busy", 32'(busy), 32'd1);
        chk("ignored_hold", 32'(bcd_out), 32'h9227465);
        wait_done();

        pulse(28'd12345, 1'b0, '0, 1'b0);
        repeat (12) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_bcd", 32'(bcd_out), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_ovf", 32'(ovf), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        pulse(28'd6765, 1'b1, 28'h0006765, 1'b0);
        wait_done();

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
